multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/multicycle_controller.sv | 173 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - Multicycle RV32 control FSM (optional ILLEGAL_TRAP_EN adds a sticky TRAP state)
module multicycle_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       trap,
    output logic [3:0] state_dbg
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
`ifdef ILLEGAL_TRAP_EN
        LUI      = 4'd11,
        TRAP     = 4'd12
`else
        LUI      = 4'd11
`endif
    } state_t;

    state_t state, state_next;
    logic   run_q;
    logic   active;

    // run_q delays the first request to the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            run_q <= 1'b0;
        end else begin
            state <= state_next;
            run_q <= 1'b1;
        end
    end

    // Gating with rst_n keeps every enable low the instant reset asserts
    assign active    = rst_n & run_q;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd0;
        result_src = 2'd0;
        alu_op     = 2'd0;
        imm_src    = 3'd0;
        trap       = 1'b0;
        if (!active) begin
            state_next = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        state_next = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_a = 2'd1;
                    alu_src_b = 2'd1;
                    imm_src   = 3'd2;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_next = MEMADR;
                        OP_RTYPE:          state_next = EXECR;
                        OP_ITYPE:          state_next = EXECI;
                        OP_BEQ:            state_next = BEQ;
                        OP_JAL:            state_next = JAL;
                        OP_LUI:            state_next = LUI;
`ifdef ILLEGAL_TRAP_EN
                        default:           state_next = TRAP;
`else
                        default:           state_next = FETCH;
`endif
                    endcase
                end
                MEMADR: begin
                    imm_src    = (opcode == OP_STORE) ? 3'd1 : 3'd0;
                    state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_next = MEMWB;
                end
                MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_next = FETCH;
                end
                MEMWB: begin
                    result_src = 2'd1;
                    reg_write  = 1'b1;
                    state_next = FETCH;
                end
                EXECR: begin
                    alu_op     = 2'd2;
                    state_next = ALUWB;
                end
                EXECI: begin
                    alu_op     = 2'd2;
                    alu_src_b  = 2'd1;
                    state_next = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    state_next = FETCH;
                end
                BEQ: begin
                    alu_op     = 2'd1;
                    pc_write   = zero;
                    state_next = FETCH;
                end
                JAL: begin
                    imm_src    = 3'd3;
                    pc_write   = 1'b1;
                    state_next = ALUWB;
                end
                LUI: begin
                    imm_src    = 3'd4;
                    result_src = 2'd3;
                    reg_write  = 1'b1;
                    state_next = FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                TRAP: begin
                    trap = 1'b1;
                end
`endif
                default: state_next = FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - Directed bench for multicycle_controller with an instruction-path model
module tb_multicycle_controller;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, pc_write, ir_write, reg_write, trap;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0] imm_src;
    logic [3:0] state_dbg;
    logic [17:0] dut_vec;

    int checks = 0;
    int failures = 0;
    int m_state = 0;
    bit m_active = 1'b0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .pc_write(pc_write),
        .ir_write(ir_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .imm_src(imm_src), .trap(trap), .state_dbg(state_dbg)
    );

    assign dut_vec = {mem_req, mem_we, adr_src, pc_write, ir_write, reg_write,
                      alu_src_a, alu_src_b, result_src, alu_op, imm_src, trap};

    // State path of each instruction class, one nibble per step, F terminates
    function automatic logic [23:0] path_of(input logic [6:0] op);
        case (op)
            OP_LOAD:  return 24'hF43210;
            OP_STORE: return 24'hFF5210;
            OP_RTYPE: return 24'hFF8610;
            OP_ITYPE: return 24'hFF8710;
            OP_BEQ:   return 24'hFFF910;
            OP_JAL:   return 24'hFF8A10;
            OP_LUI:   return 24'hFFFB10;
`ifdef ILLEGAL_TRAP_EN
            default:  return 24'hFFFC10;
`else
            default:  return 24'hFFFF10;
`endif
        endcase
    endfunction

    function automatic int model_next(input int s, input logic [6:0] op, input logic rdy);
        logic [23:0] p;
        int nxt;
        if (s == 0) return rdy ? 1 : 0;
        if ((s == 3 || s == 5) && !rdy) return s;
        if (s == 12) return 12;
        p = path_of(op);
        for (int i = 0; i < 5; i++) begin
            if (int'((p >> (4 * i)) & 24'hF) == s) begin
                nxt = int'((p >> (4 * (i + 1))) & 24'hF);
                return (nxt == 15) ? 0 : nxt;
            end
        end
        return 0;
    endfunction

    function automatic logic [17:0] model_out(input int s, input bit act, input logic rn,
                                              input logic [6:0] op, input logic z, input logic rdy);
        logic o_req, o_we, o_adr, o_pcw, o_irw, o_rw, o_trap;
        logic [1:0] o_a, o_b, o_res, o_op;
        logic [2:0] o_imm;
        if (!rn || !act) return '0;
        o_req  = (s == 0 || s == 3 || s == 5);
        o_we   = (s == 5);
        o_adr  = (s == 3 || s == 5);
        o_irw  = (s == 0) && rdy;
        o_pcw  = ((s == 0) && rdy) || (s == 10) || ((s == 9) && z);
        o_rw   = (s == 4 || s == 8 || s == 11);
        o_a    = (s == 1) ? 2'd1 : 2'd0;
        o_b    = (s == 1 || s == 7) ? 2'd1 : 2'd0;
        o_res  = (s == 4) ? 2'd1 : (s == 11) ? 2'd3 : 2'd0;
        o_op   = (s == 6 || s == 7) ? 2'd2 : (s == 9) ? 2'd1 : 2'd0;
        o_imm  = (s == 1) ? 3'd2 : (s == 2) ? ((op == OP_STORE) ? 3'd1 : 3'd0) :
                 (s == 10) ? 3'd3 : (s == 11) ? 3'd4 : 3'd0;
        o_trap = (s == 12);
        return {o_req, o_we, o_adr, o_pcw, o_irw, o_rw, o_a, o_b, o_res, o_op, o_imm, o_trap};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state  <= 0;
            m_active <= 1'b0;
        end else if (!m_active) begin
            m_active <= 1'b1;
        end else begin
            m_state <= model_next(m_state, opcode, mem_ready);
        end
    end

    always @(negedge clk) begin
        chk("state_dbg", {28'd0, state_dbg}, m_state);
        chk("outputs", {14'd0, dut_vec}, {14'd0, model_out(m_state, m_active, rst_n, opcode, zero, mem_ready)});
    end

    // Runs one instruction from FETCH until FETCH recurs; records per-cycle observations
    task automatic run_instr(input logic [6:0] op, input logic z, input int mem_wait,
                             output logic [31:0] spack, output int rw_mask,
                             output int we_cnt, output int pcw_beq);
        int waits = 0;
        bit done = 0;
        spack = 0; rw_mask = 0; we_cnt = 0; pcw_beq = 0;
        opcode = op;
        zero = z;
        for (int c = 0; c < 40 && !done; c++) begin
            mem_ready = 1'b1;
            if ((m_state == 3 || m_state == 5) && waits < mem_wait) begin
                mem_ready = 1'b0;
                waits++;
            end
            #1;
            if (c < 8) spack = spack | ({28'd0, state_dbg} << (4 * c));
            if (reg_write) rw_mask = rw_mask | (1 << c);
            if (mem_req && mem_we) we_cnt++;
            if (state_dbg == 4'd9 && pc_write) pcw_beq++;
            if (c > 0 && state_dbg == 4'd0) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("instr_done", {31'd0, done}, 32'd1);
    endtask

    logic [31:0] sp;
    int rw, wc, pb, trap_cnt;

    initial begin
        rst_n = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 mem_ready = 1'b1;
        #2;
        chk("reset_outputs", {14'd0, dut_vec}, 32'd0);
        chk("reset_state", {28'd0, state_dbg}, 32'd0);
        rst_n = 1'b1;
        #1 chk("pre_edge_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1 chk("first_edge_mem_req", {31'd0, mem_req}, 32'd1);

        run_instr(OP_LOAD, 1'b0, 0, sp, rw, wc, pb);
        chk("lw_path", sp, 32'h00043210);
        chk("lw_reg_write", rw, 32'h10);

        run_instr(OP_STORE, 1'b0, 3, sp, rw, wc, pb);
        chk("sw_path", sp, 32'h05555210);
        chk("sw_req_we_cycles", wc, 4);
        chk("sw_no_reg_write", rw, 0);

        run_instr(OP_BEQ, 1'b1, 0, sp, rw, wc, pb);
        chk("beq_taken_path", sp, 32'h0910);
        chk("beq_taken_pc_write", pb, 1);
        run_instr(OP_BEQ, 1'b0, 0, sp, rw, wc, pb);
        chk("beq_not_taken_pc_write", pb, 0);

        run_instr(OP_RTYPE, 1'b0, 0, sp, rw, wc, pb);
        chk("rtype_path", sp, 32'h08610);
        run_instr(OP_ITYPE, 1'b0, 0, sp, rw, wc, pb);
        chk("itype_path", sp, 32'h08710);
        run_instr(OP_JAL, 1'b0, 0, sp, rw, wc, pb);
        chk("jal_path", sp, 32'h08A10);
        run_instr(OP_LUI, 1'b0, 0, sp, rw, wc, pb);
        chk("lui_path", sp, 32'h0B10);
        chk("lui_reg_write", rw, 32'h4);

`ifdef ILLEGAL_TRAP_EN
        opcode = OP_BAD;
        mem_ready = 1'b1;
        trap_cnt = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (trap) trap_cnt++;
            @(posedge clk);
            #1;
        end
        chk("trap_cycles", trap_cnt, 10);
        chk("trap_state", {28'd0, state_dbg}, 32'd12);
        rst_n = 1'b0;
        #1 chk("trap_cleared", {31'd0, trap}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
`else
        run_instr(OP_BAD, 1'b0, 0, sp, rw, wc, pb);
        chk("illegal_nop_path", sp, 32'h010);
`endif

        opcode = OP_LOAD;
        mem_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        @(posedge clk);
        #1 chk("in_memread", {28'd0, state_dbg}, 32'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {14'd0, dut_vec}, 32'd0);
        chk("async_reset_state", {28'd0, state_dbg}, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("release_state", {28'd0, state_dbg}, 32'd0);
        chk("release_mem_req", {31'd0, mem_req}, 32'd0);
        @(posedge clk);
        #1 chk("release_first_edge_mem_req", {31'd0, mem_req}, 32'd1);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
